// File: rtl/sign_apply_pipe.sv
// sign_apply_pipe: two-stage valid/ready pipeline that applies the product
// sign to an unsigned partial-product magnitude. The result is OUT_W bits
// wide. Overflow is flagged, and the result is saturated or wrapped.
//
// Ports:
//   iClk, iRstN        clock (rising edge), async active-low reset
//   iFlush             synchronous clear of both pipeline valid bits
//   iValid / oReady    input handshake (oReady is combinational from iReady)
//   iMag               unsigned magnitude, MAG_W bits
//   iNegativeA/B       operand sign flags
//   iSignedMode        1 = apply sign, 0 = unsigned pass-through
//   iTag               sideband tag, TAG_W bits
//   oValid / iReady    output handshake
//   oDat, oOvf, oTag   registered result, overflow flag and tag
module sign_apply_pipe #(
  parameter int unsigned MAG_W  = 14,
  parameter int unsigned OUT_W  = 16,
  parameter int unsigned SAT_EN = 1,
  parameter int unsigned TAG_W  = 4
) (
  input  logic             iClk,
  input  logic             iRstN,
  input  logic             iFlush,
  input  logic             iValid,
  output logic             oReady,
  input  logic [MAG_W-1:0] iMag,
  input  logic             iNegativeA,
  input  logic             iNegativeB,
  input  logic             iSignedMode,
  input  logic [TAG_W-1:0] iTag,
  output logic             oValid,
  input  logic             iReady,
  output logic [OUT_W-1:0] oDat,
  output logic             oOvf,
  output logic [TAG_W-1:0] oTag
);

  // Compare width: wide enough to hold the value and every output bound as signed numbers.
  localparam int unsigned CW = ((MAG_W > OUT_W) ? MAG_W : OUT_W) + 2;

  localparam logic [CW-1:0] S_MAX = {{(CW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic [CW-1:0] S_MIN = {{(CW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic [CW-1:0] U_MAX = {{(CW-OUT_W){1'b0}}, {OUT_W{1'b1}}};

  logic             s1Valid;
  logic             s1Neg;
  logic             s1Signed;
  logic [MAG_W-1:0] s1Mag;
  logic [TAG_W-1:0] s1Tag;

  logic             s2Valid;
  logic [OUT_W-1:0] datQ;
  logic             ovfQ;
  logic [TAG_W-1:0] tagQ;

  logic             adv1;
  logic             adv2;

  logic [CW-1:0]    magExt;
  logic [CW-1:0]    value;
  logic [OUT_W-1:0] satDat;
  logic [OUT_W-1:0] resDat;
  logic             resOvf;

  // Stage advance conditions; a stage moves when it is empty or its consumer moves.
  always_comb begin
    adv2   = ~s2Valid | iReady;
    adv1   = ~s1Valid | adv2;
    oReady = adv1;
  end

  // Stage-2 arithmetic: full-precision signed value, range check, then saturate or wrap.
  always_comb begin
    magExt = CW'(s1Mag);
    value  = s1Neg ? (~magExt + CW'(1)) : magExt;
    resOvf = 1'b0;
    satDat = value[OUT_W-1:0];
    if (s1Signed) begin
      if ($signed(value) > $signed(S_MAX)) begin
        resOvf = 1'b1;
        satDat = S_MAX[OUT_W-1:0];
      end else if ($signed(value) < $signed(S_MIN)) begin
        resOvf = 1'b1;
        satDat = S_MIN[OUT_W-1:0];
      end
    end else if (magExt > U_MAX) begin
      resOvf = 1'b1;
      satDat = U_MAX[OUT_W-1:0];
    end
    resDat = value[OUT_W-1:0];
    if (resOvf && (SAT_EN != 0)) begin
      resDat = satDat;
    end
  end

  // Valid bits: flush takes priority over any advance.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      s1Valid <= 1'b0;
      s2Valid <= 1'b0;
    end else if (iFlush) begin
      s1Valid <= 1'b0;
      s2Valid <= 1'b0;
    end else begin
      if (adv1) s1Valid <= iValid;
      if (adv2) s2Valid <= s1Valid;
    end
  end

  // Stage-1 data: load only on an accepted beat to limit toggling.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      s1Neg    <= 1'b0;
      s1Signed <= 1'b0;
      s1Mag    <= '0;
      s1Tag    <= '0;
    end else if (adv1 && iValid) begin
      s1Neg    <= iSignedMode & (iNegativeA ^ iNegativeB);
      s1Signed <= iSignedMode;
      s1Mag    <= iMag;
      s1Tag    <= iTag;
    end
  end

  // Stage-2 data: held while the output is stalled.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      datQ <= '0;
      ovfQ <= 1'b0;
      tagQ <= '0;
    end else if (adv2 && s1Valid) begin
      datQ <= resDat;
      ovfQ <= resOvf;
      tagQ <= s1Tag;
    end
  end

  assign oValid = s2Valid;
  assign oDat   = datQ;
  assign oOvf   = ovfQ;
  assign oTag   = tagQ;

endmodule

// File: tb/tb_sign_apply_pipe.sv
// Scoreboard bench for sign_apply_pipe: one default instance (16-bit out) and
// two 8-bit instances (saturating and wrapping) sharing the data inputs.
`timescale 1ns/1ps
module tb_sign_apply_pipe;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstN, flush, ready, negA, negB, signedMode;
  logic [13:0] mag;
  logic [3:0]  tag;
  logic        inV0, inV1, inV2;
  logic        rdy0, rdy1, rdy2;
  logic        outV0, outV1, outV2;
  logic [15:0] d0;
  logic [7:0]  d1, d2;
  logic        ovf0, ovf1, ovf2;
  logic [3:0]  t0, t1, t2;

  sign_apply_pipe u0 (
    .iClk(clk), .iRstN(rstN), .iFlush(flush), .iValid(inV0), .oReady(rdy0),
    .iMag(mag), .iNegativeA(negA), .iNegativeB(negB), .iSignedMode(signedMode),
    .iTag(tag), .oValid(outV0), .iReady(ready), .oDat(d0), .oOvf(ovf0), .oTag(t0));

  sign_apply_pipe #(.OUT_W(8), .SAT_EN(1)) u1 (
    .iClk(clk), .iRstN(rstN), .iFlush(flush), .iValid(inV1), .oReady(rdy1),
    .iMag(mag), .iNegativeA(negA), .iNegativeB(negB), .iSignedMode(signedMode),
    .iTag(tag), .oValid(outV1), .iReady(ready), .oDat(d1), .oOvf(ovf1), .oTag(t1));

  sign_apply_pipe #(.OUT_W(8), .SAT_EN(0)) u2 (
    .iClk(clk), .iRstN(rstN), .iFlush(flush), .iValid(inV2), .oReady(rdy2),
    .iMag(mag), .iNegativeA(negA), .iNegativeB(negB), .iSignedMode(signedMode),
    .iTag(tag), .oValid(outV2), .iReady(ready), .oDat(d2), .oOvf(ovf2), .oTag(t2));

  typedef struct packed {
    logic [15:0] dat;
    logic        ovf;
    logic [3:0]  tag;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int   nChecks = 0;
  int   nFails  = 0;
  int   occ     = 0;
  logic done    = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare the presented beat with the head of its queue; pop on transfer.
  task automatic mon(input int k, input logic vld, input logic [15:0] dat,
                     input logic ovf, input logic [3:0] tg);
    exp_t e;
    int   sz;
    if (!vld) return;
    sz = (k == 0) ? q0.size() : (k == 1) ? q1.size() : q2.size();
    if (sz == 0) begin
      nChecks++;
      nFails++;
      $display("FAIL unexpected_beat_dut%0d: got dat=%0h tag=%0h, expected no beat", k, dat, tg);
      return;
    end
    e = (k == 0) ? q0[0] : (k == 1) ? q1[0] : q2[0];
    check($sformatf("dat_dut%0d_tag%0d", k, e.tag), 32'(dat), 32'(e.dat));
    check($sformatf("ovf_dut%0d_tag%0d", k, e.tag), 32'(ovf), 32'(e.ovf));
    check($sformatf("tag_dut%0d", k), 32'(tg), 32'(e.tag));
    if (ready) begin
      if (k == 0) void'(q0.pop_front());
      else if (k == 1) void'(q1.pop_front());
      else void'(q2.pop_front());
    end
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rstN) begin
      q0.delete();
      q1.delete();
      q2.delete();
      occ = 0;
    end else begin
      mon(0, outV0, d0, ovf0, t0);
      mon(1, outV1, {8'h00, d1}, ovf1, t1);
      mon(2, outV2, {8'h00, d2}, ovf2, t2);
      // oReady drops only when both stages hold a beat and downstream stalls.
      check("oReady_dut0", 32'(rdy0), 32'(!(occ == 2 && !ready)));
      if (flush) begin
        occ = 0;
        q0.delete();
        q1.delete();
        q2.delete();
      end else begin
        occ = occ + int'(inV0 && rdy0) - int'(outV0 && ready);
      end
    end
  end

  // Present one beat to the selected DUTs; push expectations when each accepts.
  task automatic send(input logic [2:0] sel, input logic [13:0] m, input logic a,
                      input logic b, input logic sm, input logic [3:0] tg,
                      input logic [15:0] e0, input logic o0,
                      input logic [7:0] e1, input logic o1,
                      input logic [7:0] e2, input logic o2);
    logic [2:0] pend;
    int         guard;
    exp_t       e;
    pend = sel;
    guard = 0;
    mag = m; negA = a; negB = b; signedMode = sm; tag = tg;
    inV0 = sel[0]; inV1 = sel[1]; inV2 = sel[2];
    while (pend != 3'b000 && guard < 100) begin
      @(negedge clk);
      if (pend[0] && rdy0) begin e = {e0, o0, tg}; if (!flush) q0.push_back(e); pend[0] = 1'b0; end
      if (pend[1] && rdy1) begin e = {8'h00, e1, o1, tg}; if (!flush) q1.push_back(e); pend[1] = 1'b0; end
      if (pend[2] && rdy2) begin e = {8'h00, e2, o2, tg}; if (!flush) q2.push_back(e); pend[2] = 1'b0; end
      @(posedge clk); #1;
      inV0 = pend[0]; inV1 = pend[1]; inV2 = pend[2];
      guard++;
    end
    check("send_accept_timeout", 32'(pend), 32'(0));
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic waitDrain();
    int g;
    g = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    check("drain_timeout", 32'(q0.size() + q1.size() + q2.size()), 32'(0));
  endtask

  // Stream driver for the backpressure phase.
  task automatic streamBeats();
    for (int t = 0; t < 8; t++) begin
      send(3'b001, 14'(10 * t + 5), 1'b0, 1'b0, 1'b1, 4'(t),
           16'(10 * t + 5), 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    end
    done = 1'b1;
  endtask

  task automatic toggleReady();
    while (!done) begin
      ready = 1'b0;
      idle($urandom_range(3, 5));
      ready = 1'b1;
      idle($urandom_range(1, 3));
    end
  endtask

  initial begin
    rstN = 1'b0; flush = 1'b0; ready = 1'b1;
    negA = 1'b0; negB = 1'b0; signedMode = 1'b1; mag = '0; tag = '0;
    inV0 = 1'b0; inV1 = 1'b0; inV2 = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_oValid0", 32'(outV0), 32'(0));
    check("rst_oDat0",   32'(d0),    32'(0));
    check("rst_oOvf0",   32'(ovf0),  32'(0));
    check("rst_oTag0",   32'(t0),    32'(0));
    check("rst_oValid1", 32'(outV1), 32'(0));
    rstN = 1'b1;
    #1;
    check("rst_oReady0", 32'(rdy0), 32'(1));
    @(posedge clk); #1;

    // First beat: absent after the capture edge, present after the next one.
    send(3'b001, 14'd100, 1'b1, 1'b0, 1'b1, 4'd1, 16'hFF9C, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    check("latency_edge1", 32'(outV0), 32'(0));
    @(posedge clk); #1;
    check("latency_edge2", 32'(outV0), 32'(1));
    waitDrain();

    // Default-width vectors, back to back.
    send(3'b001, 14'd100,   1'b1, 1'b1, 1'b1, 4'd2, 16'h0064, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    send(3'b001, 14'd100,   1'b0, 1'b1, 1'b1, 4'd3, 16'hFF9C, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    send(3'b001, 14'd16383, 1'b1, 1'b0, 1'b1, 4'd4, 16'hC001, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    send(3'b001, 14'd0,     1'b0, 1'b1, 1'b1, 4'd5, 16'h0000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    send(3'b001, 14'd16383, 1'b1, 1'b0, 1'b0, 4'd6, 16'h3FFF, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    send(3'b001, 14'd16383, 1'b0, 1'b0, 1'b1, 4'd7, 16'h3FFF, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    waitDrain();

    // 8-bit outputs: saturating (dut1) and wrapping (dut2).
    send(3'b110, 14'd200, 1'b0, 1'b0, 1'b1, 4'd1, 16'h0, 1'b0, 8'h7F, 1'b1, 8'hC8, 1'b1);
    send(3'b110, 14'd128, 1'b1, 1'b0, 1'b1, 4'd2, 16'h0, 1'b0, 8'h80, 1'b0, 8'h80, 1'b0);
    send(3'b110, 14'd129, 1'b0, 1'b1, 1'b1, 4'd3, 16'h0, 1'b0, 8'h80, 1'b1, 8'h7F, 1'b1);
    send(3'b110, 14'd300, 1'b1, 1'b0, 1'b0, 4'd4, 16'h0, 1'b0, 8'hFF, 1'b1, 8'h2C, 1'b1);
    send(3'b110, 14'd255, 1'b1, 1'b0, 1'b0, 4'd5, 16'h0, 1'b0, 8'hFF, 1'b0, 8'hFF, 1'b0);
    send(3'b110, 14'd127, 1'b0, 1'b0, 1'b1, 4'd6, 16'h0, 1'b0, 8'h7F, 1'b0, 8'h7F, 1'b0);
    send(3'b110, 14'd0,   1'b1, 1'b0, 1'b1, 4'd7, 16'h0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    waitDrain();

    // Backpressure: tagged stream with stall periods of at least three cycles.
    done = 1'b0;
    fork
      streamBeats();
      toggleReady();
    join
    ready = 1'b1;
    waitDrain();

    // Flush with a full pipe; the offered beat cannot be accepted.
    ready = 1'b0;
    send(3'b001, 14'd9,  1'b0, 1'b0, 1'b1, 4'd9,  16'd9,  1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    send(3'b001, 14'd10, 1'b0, 1'b0, 1'b1, 4'd10, 16'd10, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    check("full_oReady0", 32'(rdy0), 32'(0));
    mag = 14'd11; tag = 4'd11; inV0 = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; inV0 = 1'b0;
    check("flush_oValid_full", 32'(outV0), 32'(0));
    ready = 1'b1;
    idle(5);
    check("flush_quiet_full", 32'(outV0), 32'(0));

    // Flush while a new beat is actually handshaked.
    ready = 1'b0;
    send(3'b001, 14'd12, 1'b0, 1'b0, 1'b1, 4'd12, 16'd12, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    idle(1);
    mag = 14'd13; tag = 4'd13; inV0 = 1'b1; flush = 1'b1;
    #1;
    check("flush_accepting_oReady0", 32'(rdy0), 32'(1));
    @(posedge clk); #1;
    flush = 1'b0; inV0 = 1'b0;
    check("flush_oValid_hs", 32'(outV0), 32'(0));
    ready = 1'b1;
    idle(5);
    check("flush_quiet_hs", 32'(outV0), 32'(0));

    // Reset mid-stream: oValid falls without a clock edge.
    send(3'b001, 14'd1, 1'b0, 1'b0, 1'b1, 4'd1, 16'd1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    send(3'b001, 14'd2, 1'b0, 1'b0, 1'b1, 4'd2, 16'd2, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    rstN = 1'b0;
    #1;
    check("reset_async_oValid", 32'(outV0), 32'(0));
    @(posedge clk); #1;
    rstN = 1'b1;
    @(posedge clk); #1;
    send(3'b001, 14'd77, 1'b1, 1'b0, 1'b1, 4'd3, 16'hFFB3, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    check("post_reset_edge1", 32'(outV0), 32'(0));
    @(posedge clk); #1;
    check("post_reset_edge2", 32'(outV0), 32'(1));
    waitDrain();
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
